// File: rtl/tff_bank_sequencer.sv
// -----------------------------------------------------------------------------
// tff_bank_sequencer
//
// Drives a WIDTH-bit bank of reset-less T flip-flops so that it counts up,
// counts down, loads a target, or inverts. The sequencer issues one registered
// toggle vector per clock and tracks the value the bank should hold. Every
// returned q is compared against that expectation, and a sticky error is
// raised on any divergence. Because the bank has no reset, each command starts
// from the q value sampled at the moment the command is accepted.
//
// Parameters
//   WIDTH  bank width in bits
//   CNT_W  step-count / argument width (must be >= WIDTH)
//
// Ports
//   clk        rising-edge clock shared with the bank
//   rst_n      asynchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  high only while idle; a command transfers on valid && ready
//   cmd_op     00 UP, 01 DOWN, 10 LOAD, 11 INVERT
//   cmd_arg    step count for UP/DOWN; target (low WIDTH bits) for LOAD
//   q_in       bank q outputs
//   t_out      registered toggle vector to the bank t inputs
//   busy       high from acceptance until completion
//   done       one-cycle completion pulse
//   err        sticky mismatch flag, cleared when the next command is accepted
//   q_exp      expected bank value, one cycle behind the internal state
// -----------------------------------------------------------------------------
module tff_bank_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] t_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] q_exp
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_UP     = 2'b00;
  localparam logic [1:0] OP_DOWN   = 2'b01;
  localparam logic [1:0] OP_LOAD   = 2'b10;
  localparam logic [1:0] OP_INVERT = 2'b11;

  state_t           state;
  logic [1:0]       op;
  logic [WIDTH-1:0] load_tgt;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] next_val;
  logic [CNT_W-1:0] remaining;
  logic             drain_cnt;
  logic             tv;   // a toggle was issued this cycle
  logic             cv;   // q_in this cycle must equal q_exp

  assign cmd_ready = (state == IDLE);

  // Value the bank should hold after the current step; arithmetic wraps
  // silently modulo 2^WIDTH.
  always_comb begin
    next_val = base;
    case (op)
      OP_UP:     next_val = base + WIDTH'(1);
      OP_DOWN:   next_val = base - WIDTH'(1);
      OP_LOAD:   next_val = load_tgt;
      OP_INVERT: next_val = ~base;
      default:   next_val = base;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op        <= OP_UP;
      load_tgt  <= '0;
      base      <= '0;
      remaining <= '0;
      drain_cnt <= 1'b0;
      tv        <= 1'b0;
      cv        <= 1'b0;
      t_out     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      q_exp     <= '0;
    end else begin
      // The checker runs one cycle behind the issue: a toggle issued at Ek
      // reaches the bank at Ek+1, and q_in is compared at Ek+2.
      q_exp <= base;
      cv    <= tv;
      if (cv && (q_in != q_exp)) begin
        err <= 1'b1;
      end

      case (state)
        IDLE: begin
          t_out <= '0;
          tv    <= 1'b0;
          done  <= 1'b0;
          if (cmd_valid) begin
            base     <= q_in;
            op       <= cmd_op;
            load_tgt <= cmd_arg[WIDTH-1:0];
            err      <= 1'b0;   // overrides the check above on acceptance
            busy     <= 1'b1;
            if (cmd_op[1]) begin
              // LOAD and INVERT are always a single step.
              remaining <= CNT_W'(1);
              state     <= RUN;
            end else if (cmd_arg == '0) begin
              remaining <= '0;
              state     <= DONE;
            end else begin
              remaining <= cmd_arg;
              state     <= RUN;
            end
          end
        end

        RUN: begin
          t_out     <= base ^ next_val;
          base      <= next_val;
          tv        <= 1'b1;
          remaining <= remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            drain_cnt <= 1'b0;
            state     <= DRAIN;
          end
        end

        // Two quiet cycles so the last step's check completes before done.
        DRAIN: begin
          t_out <= '0;
          tv    <= 1'b0;
          if (drain_cnt) begin
            state <= DONE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end

        DONE: begin
          t_out <= '0;
          tv    <= 1'b0;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tff_bank_sequencer.sv
module tb_tff_bank_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic [3:0] t_out;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] q_exp;

  // Behavioural T flip-flop bank (no reset) with a preset hook and a
  // per-bit toggle suppression mask used to inject faults.
  logic [3:0] bank_q;
  logic       preset_en;
  logic [3:0] preset_val;
  logic [3:0] fault_mask;

  int checks;
  int errors;

  tff_bank_sequencer #(.WIDTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .q_in      (bank_q),
    .t_out     (t_out),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .q_exp     (q_exp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preset_en) bank_q <= preset_val;
    else           bank_q <= bank_q ^ (t_out & ~fault_mask);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] step_val(input logic [1:0] op, input logic [3:0] b,
                                          input logic [3:0] tgt);
    case (op)
      2'b00:   return 4'((int'(b) + 1) % 16);
      2'b01:   return 4'((int'(b) + 15) % 16);
      2'b10:   return tgt;
      default: return 4'(15 - int'(b));
    endcase
  endfunction

  task automatic do_preset(input logic [3:0] v);
    preset_val = v;
    preset_en  = 1'b1;
    @(negedge clk);
    preset_en  = 1'b0;
  endtask

  // Issue one command from a negedge and follow it to completion, checking
  // every toggle vector, the error timing and the completion latency.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] arg, input int fault,
                         output logic [3:0] final_q, output logic err_o);
    logic [3:0] exp_t[$];
    logic [3:0] b, nb, model_q;
    int         n, lat;
    bit         dropped, seen;
    n = op[1] ? 1 : int'(arg);
    b = bank_q;
    exp_t.delete();
    for (int k = 1; k <= n; k++) begin
      nb = step_val(op, b, arg[3:0]);
      exp_t.push_back(b ^ nb);
      b = nb;
    end
    dropped = (fault >= 1) && (fault <= n) && exp_t[fault-1][0];
    model_q = dropped ? (b ^ 4'b0001) : b;
    lat     = (n == 0) ? 1 : n + 3;

    chk("ready_idle", 32'(cmd_ready), 1);
    cmd_op    = op;
    cmd_arg   = arg;
    cmd_valid = 1'b1;
    @(negedge clk);
    chk("busy_after_accept", 32'(busy), 1);
    chk("err_cleared", 32'(err), 0);
    seen = 0;
    for (int c = 1; c <= 300 && !seen; c++) begin
      // Commands offered while busy must be ignored.
      cmd_op  = 2'($urandom);
      cmd_arg = 8'($urandom);
      @(negedge clk);
      fault_mask = (c == fault) ? 4'b0001 : 4'b0000;
      if (c < lat && c == 1) chk("ready_low_busy", 32'(cmd_ready), 0);
      if (c <= n) chk($sformatf("t_step%0d", c), 32'(t_out), 32'(exp_t[c-1]));
      else if (c <= n + 2 && n > 0) chk("t_drain", 32'(t_out), 0);
      if (dropped && c == fault + 1) chk("err_before_check", 32'(err), 0);
      if (dropped && c == fault + 2) chk("err_at_check", 32'(err), 1);
      if (done) begin
        seen = 1;
        chk("done_latency", 32'(c), 32'(lat));
      end
    end
    cmd_valid  = 1'b0;
    fault_mask = 4'b0000;
    if (!seen) chk("done_timeout", 0, 1);
    chk("err_at_done", 32'(err), 32'(dropped));
    chk("bank_final", 32'(bank_q), 32'(model_q));
    chk("q_exp_final", 32'(q_exp), 32'(b));
    chk("ready_with_done", 32'(cmd_ready), 1);
    chk("busy_at_done", 32'(busy), 0);
    final_q = bank_q;
    err_o   = err;
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
    chk("err_sticky_after_done", 32'(err), 32'(dropped));
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] arg;
    int         fault;
    bit         pre;
    logic [3:0] pre_q;
    logic [3:0] exp_q;
    logic       exp_err;
  } vec_t;

  vec_t       tbl[8];
  logic [3:0] fq;
  logic       fe;
  int         done_cnt;

  initial begin
    checks     = 0;
    errors     = 0;
    cmd_valid  = 1'b0;
    cmd_op     = 2'b00;
    cmd_arg    = 8'h00;
    preset_en  = 1'b0;
    preset_val = 4'h0;
    fault_mask = 4'h0;
    bank_q     = 4'h0;

    tbl[0] = '{2'b00, 8'd5,  0, 1'b1, 4'h0, 4'h5, 1'b0}; // UP 5 from 0000
    tbl[1] = '{2'b01, 8'd1,  0, 1'b1, 4'h0, 4'hF, 1'b0}; // DOWN wraps to 1111
    tbl[2] = '{2'b00, 8'd1,  0, 1'b0, 4'h0, 4'h0, 1'b0}; // UP wraps to 0000
    tbl[3] = '{2'b10, 8'hFA, 0, 1'b1, 4'h6, 4'hA, 1'b0}; // LOAD 1010 from 0110
    tbl[4] = '{2'b10, 8'h0A, 0, 1'b0, 4'h0, 4'hA, 1'b0}; // LOAD same value
    tbl[5] = '{2'b00, 8'd4,  2, 1'b1, 4'h0, 4'h5, 1'b1}; // bit0 dropped on step 2
    tbl[6] = '{2'b00, 8'd0,  0, 1'b0, 4'h0, 4'h5, 1'b0}; // N=0, clears err
    tbl[7] = '{2'b11, 8'h5C, 0, 1'b1, 4'h3, 4'hC, 1'b0}; // INVERT 0011

    // Reset asserted before any edge: outputs are zero immediately.
    rst_n = 1'b0;
    #1;
    chk("rst_t_out", 32'(t_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_q_exp", 32'(q_exp), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 32'(cmd_ready), 1);
    chk("rel_t_out", 32'(t_out), 0);
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].pre) do_preset(tbl[i].pre_q);
      run_cmd(tbl[i].op, tbl[i].arg, tbl[i].fault, fq, fe);
      chk($sformatf("vec%0d_q", i), 32'(fq), 32'(tbl[i].exp_q));
      chk($sformatf("vec%0d_err", i), 32'(fe), 32'(tbl[i].exp_err));
    end

    // Reset during step 3 of UP 10: toggles stop at once, no done appears.
    do_preset(4'h0);
    cmd_op    = 2'b00;
    cmd_arg   = 8'd10;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_step3_t", 32'(t_out), 32'h1);
    chk("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_t_out", 32'(t_out), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_q_exp", 32'(q_exp), 0);
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    rst_n = 1'b1;
    #1;
    chk("mid_rel_ready", 32'(cmd_ready), 1);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("mid_no_done", 32'(done_cnt), 0);
    chk("mid_bank_held", 32'(bank_q), 32'h2);
    do_preset(4'h3);
    run_cmd(2'b11, 8'h00, 0, fq, fe);
    chk("post_rst_invert_q", 32'(fq), 32'hC);

    // Randomized commands against the reference model inside run_cmd.
    for (int i = 0; i < 40; i++) begin
      logic [1:0] rop;
      logic [7:0] rarg;
      int         rn, rf;
      rop  = 2'($urandom);
      rarg = rop[1] ? 8'($urandom) : 8'($urandom_range(12, 0));
      rn   = rop[1] ? 1 : int'(rarg);
      rf   = ($urandom_range(3, 0) == 0 && rn > 0) ? int'($urandom_range(rn, 1)) : 0;
      if ($urandom_range(3, 0) == 0) do_preset(4'($urandom));
      run_cmd(rop, rarg, rf, fq, fe);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tff_bank_sequencer.md
# tff_bank_sequencer

Controller for a WIDTH-bit bank of T flip-flops of the kind used in the sequential library (clk, t → q, no reset). It accepts commands over a valid/ready handshake and issues one registered toggle vector per clock so that the bank steps through a count or lands on a target value. It tracks the expected bank state and flags any divergence between expected and returned q. The bank itself has no reset, so every command starts from the bank's q sampled at acceptance.

## Interface
- WIDTH, 4, bank width in bits.
- CNT_W, 8, step-count / argument width; must be ≥ WIDTH.
- clk  input  1  rising-edge clock shared with the bank.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  high only in IDLE; transfer on cmd_valid && cmd_ready at a rising edge.
- cmd_op  input  2  00 UP, 01 DOWN, 10 LOAD, 11 INVERT.
- cmd_arg  input  CNT_W  step count N for UP/DOWN; target in [WIDTH-1:0] for LOAD; ignored for INVERT.
- q_in  input  WIDTH  bank q outputs.
- t_out  output  WIDTH  registered toggle vector to bank t inputs.
- busy  output  1  high from acceptance until done.
- done  output  1  one-cycle pulse at command completion.
- err  output  1  sticky mismatch flag; cleared on next acceptance.
- q_exp  output  WIDTH  expected bank value, lagging internal state by one cycle.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: cmd_ready=1, t_out=0. On accept: base ← q_in, latch op/arg, err ← 0, busy ← 1.
  - UP/DOWN: remaining ← N. N=0 goes straight to DONE with no toggles.
  - LOAD/INVERT: remaining ← 1.
  - Otherwise → RUN.
- RUN, each edge:
  - next = base+1 (UP), base−1 (DOWN), cmd_arg[WIDTH-1:0] (LOAD), ~base (INVERT).
  - Arithmetic is mod 2^WIDTH: wrap at all-ones/zero is silent.
  - t_out ← base ^ next; base ← next; tv ← 1; remaining ← remaining−1.
  - When remaining reaches 0 → DRAIN.
- DRAIN: t_out ← 0, tv ← 0; stays 2 cycles so the final step's check completes.
- DONE: done=1 for one cycle, busy ← 0 → IDLE. cmd_ready is high in that same cycle.
- Checking, every edge:
  - q_exp ← base; cv ← tv.
  - If cv=1 and q_in ≠ q_exp, then err ← 1.
  - err stays high through done and until the next accept.
- LOAD with target == q_in: one step, t_out=0, no bank change, done normally.
- cmd_valid while busy: ignored (cmd_ready=0), no side effect.

## Timing
- Accept at edge E0; steps at E1..EN; t_out of step k visible after Ek.
- The bank toggles at Ek+1; q_in equals base(Ek) after Ek+1 and is checked at Ek+2.
- DRAIN covers EN+1, EN+2; done is high in the cycle after EN+3; cmd_ready returns with done.
- Command-to-done latency is N+3 edges (LOAD/INVERT: 4); for N=0, done follows E1.
- Throughput: one toggle per clock during RUN; back-to-back commands are spaced by the DONE cycle.
- Reset (rst_n low, any time, asynchronous): state IDLE, t_out=0, busy=0, done=0, err=0, q_exp=0, remaining=0, tv=cv=0.
  - The bank keeps its q. After release, cmd_ready=1 on the first cycle.
  - Any in-flight command is dropped with no done.

## Test plan
- Reset: drive rst_n=0 mid-cycle → all outputs 0 immediately; release → cmd_ready=1, t_out=0000.
- UP, N=5, q_in=0000, behavioural TFF bank:
  - t_out sequence 0001, 0011, 0001, 0111, 0001 at E1..E5.
  - Final q=0101, done after E8, err=0.
- Wrap: DOWN, N=1, q=0000 → t_out=1111, q=1111. Then UP, N=1 → t_out=1111, q=0000.
- LOAD 1010 from q=0110 → single t_out=1100, q=1010. Then LOAD 1010 again → t_out=0000, done, err=0.
- Fault injection: the bank model drops bit0 on step 2 of UP, N=4 from 0000.
  - err=1 at the check edge and stays through done.
  - Next accepted command clears err.
- Reset mid-command: rst_n low during step 3 of UP, N=10 → t_out=0 asynchronously, no done.
  - After release, INVERT with q=0011 → t_out=1111, q=1100.
